mips_run_controller: RTL

MIPS_RUN_CONTROLLER -- requirements
Module: mips_run_controller

---
 rtl/mips_run_pkg.sv | 17 +
 rtl/mips_halt_detect.sv | 44 ++++
 rtl/mips_run_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_run_pkg.sv
// Shared state encoding and parameter defaults for the MIPS run controller.
package mips_run_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_DONE
  } run_state_t;

  localparam int DEF_INSTR_W     = 32;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_IMEM_DEPTH  = 256;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 10000;
  localparam int DEF_HALT_REPEAT = 2;
endpackage

// File: rtl/mips_halt_detect.sv
// Detects a CPU that keeps presenting the same unstalled PC (self-loop halt).
module mips_halt_detect #(
  parameter int ADDR_W      = 8,
  parameter int HALT_REPEAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              active,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic              halt
);
  localparam int HW = $clog2(HALT_REPEAT + 1);

  logic [ADDR_W-1:0] prev_pc;
  logic              first;
  logic [HW-1:0]     count;
  logic [HW-1:0]     count_next;

  // The first active cycle has no meaningful previous PC, so it never counts.
  always_comb begin
    count_next = count;
    if (active && !first && !stall) begin
      count_next = (pc == prev_pc) ? count + HW'(1) : '0;
    end
  end

  assign halt = active && (count_next == HW'(HALT_REPEAT));

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      prev_pc <= '0;
      first   <= 1'b1;
      count   <= '0;
    end else begin
      prev_pc <= pc;
      if (active) begin
        first <= 1'b0;
        count <= count_next;
      end
    end
  end
endmodule

// File: rtl/mips_run_controller.sv
// Loads a program into instruction memory, then runs the CPU until it halts
// on a repeated PC or hits the cycle timeout.
module mips_run_controller
  import mips_run_pkg::*;
#(
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int IMEM_DEPTH  = DEF_IMEM_DEPTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               start,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_run,
  input  logic [ADDR_W-1:0]  cpu_pc,
  input  logic               cpu_stall,
  output logic [ADDR_W:0]    word_count,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               overflow
);
  localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W + 1)'(IMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(TIMEOUT - 1);

  run_state_t state;
  logic       handshake;
  logic       halt;
  logic       restart;

  // Load handshake: a word transfers in any cycle where load_valid and
  // load_ready are both high; load_ready depends only on state, never on valid.
  assign load_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign handshake  = load_valid && load_ready;
  assign imem_we    = handshake;
  assign imem_addr  = word_count[ADDR_W-1:0];
  assign imem_wdata = handshake ? load_data : '0;

  assign cpu_reset  = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_ARMED);
  assign cpu_run    = (state == ST_RUN);
  assign busy       = (state == ST_LOAD) || (state == ST_RUN);
  assign done       = (state == ST_DONE);

  assign restart = clear || ((state == ST_ARMED) && start);

  mips_halt_detect #(
    .ADDR_W      (ADDR_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .active  (cpu_run),
    .pc      (cpu_pc),
    .stall   (cpu_stall),
    .halt    (halt)
  );

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= ST_IDLE;
      word_count  <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (handshake) begin
            word_count <= word_count + (ADDR_W + 1)'(1);
            if (load_last) begin
              state <= ST_ARMED;
            end else if (word_count == LAST_WORD) begin
              overflow <= 1'b1;
              state    <= ST_ARMED;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_ARMED: begin
          if (start) begin
            state       <= ST_RUN;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        ST_RUN: begin
          // The exiting cycle is not counted, so cycle_count holds the index
          // of the last RUN cycle; halt beats timeout when both coincide.
          if (halt) begin
            state <= ST_DONE;
          end else if (cycle_count == LAST_CYC) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_ARMED;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
